// File: rtl/local_pattern_table.sv
// Local-history pattern table: 32 two-bit saturating counters indexed by a
// 5-bit history pattern, with a two-stage update pipeline and forwarding.
module local_pattern_table (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       lookup_valid,
  input  logic [4:0] lookup_history,
  input  logic       update_valid,
  input  logic [4:0] update_history,
  input  logic       update_taken,
  output logic       predict_valid,
  output logic       predict_taken,
  output logic       predict_strong
);

  localparam int DEPTH = 32;
  localparam logic [1:0] CTR_INIT = 2'b01;

  function automatic logic [1:0] sat_step(input logic [1:0] old, input logic taken);
    if (taken) return (old == 2'b11) ? old : old + 2'd1;
    else       return (old == 2'b00) ? old : old - 2'd1;
  endfunction

  function automatic logic is_strong(input logic [1:0] ctr);
    return (ctr == 2'b00) || (ctr == 2'b11);
  endfunction

  logic [1:0] cnt_q [DEPTH];

  logic       vld_p1;
  logic [4:0] upd_idx_p1;
  logic       upd_taken_p1;
  logic [1:0] upd_old_p1;
  logic [1:0] upd_new_p1;

  logic [1:0] lookup_eff;
  logic [1:0] update_eff;

  assign upd_new_p1 = sat_step(upd_old_p1, upd_taken_p1);

  // The pending stage's result is not yet in the array, so both read ports forward it.
  always_comb begin
    lookup_eff = cnt_q[lookup_history];
    if (vld_p1 && (upd_idx_p1 == lookup_history)) lookup_eff = upd_new_p1;
    update_eff = cnt_q[update_history];
    if (vld_p1 && (upd_idx_p1 == update_history)) update_eff = upd_new_p1;
  end

  // Stage A -> B boundary: capture index, direction and effective old value
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1 <= 1'b0;
    else          vld_p1 <= update_valid;
  end

  always_ff @(posedge clk) begin
    if (update_valid) begin
      upd_idx_p1   <= update_history;
      upd_taken_p1 <= update_taken;
      upd_old_p1   <= update_eff;
    end
  end

  // Stage B: commit the saturated counter to the array
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CTR_INIT;
    end else if (vld_p1) begin
      cnt_q[upd_idx_p1] <= upd_new_p1;
    end
  end

  // Lookup boundary: taken/strong hold their value while no lookup is accepted
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      predict_valid  <= 1'b0;
      predict_taken  <= 1'b0;
      predict_strong <= 1'b0;
    end else begin
      predict_valid <= lookup_valid;
      if (lookup_valid) begin
        predict_taken  <= lookup_eff[1];
        predict_strong <= is_strong(lookup_eff);
      end
    end
  end

endmodule
